data_memory_unit: RTL

Data-side memory stage sitting directly downstream of the CPU's RAM port: it consumes the CPU's RAM address, write data and enables, and returns registered read data. It holds a 64-word data array plus one memory-mapped output port at a fixed address. That port feeds a small output FIFO with a valid/ready handshake toward an external consumer, such as a display or UART.

---
 rtl/data_memory_unit_pkg.sv | 22 ++
 rtl/io_fifo.sv | 72 +++++++
 rtl/data_memory_unit.sv | 73 +++++++
 3 files changed

// File: rtl/data_memory_unit_pkg.sv
// Shared constants for the data memory stage and its memory-mapped output port.
// Also used by the CPU top and by the software-side register description.
package data_memory_unit_pkg;

    localparam int unsigned nBit       = 16;
    localparam int unsigned AW         = 6;
    localparam logic [AW-1:0] IO_ADDR  = 6'h3F;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CW         = 3;

    // Status word layout returned by a read of IO_ADDR
    localparam int unsigned OVF_BIT    = nBit - 1;

    function automatic logic [nBit-1:0] status_word(input logic ovf, input logic [CW-1:0] cnt);
        logic [nBit-1:0] w;
        w          = '0;
        w[OVF_BIT] = ovf;
        w[CW-1:0]  = cnt;
        return w;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Output FIFO behind the memory-mapped port: storage, head/tail pointers,
// occupancy count and a sticky overflow flag for dropped pushes.
module io_fifo #(
    parameter int unsigned nBit       = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [nBit-1:0] push_data,
    input  logic            pop_ready,
    output logic [nBit-1:0] head_data,
    output logic            valid,
    output logic [CW-1:0]   count,
    output logic            overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    logic [nBit-1:0] store_q [FIFO_DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            pop, full, push_acc;

    // Handshake decode and next-state for pointers, count and overflow
    always_comb begin
        pop      = (count_q != '0) && pop_ready;
        full     = (count_q == CW'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot the push needs
        push_acc = push && (!full || pop);
        head_d   = pop ? head_q + PW'(1) : head_q;
        tail_d   = push_acc ? tail_q + PW'(1) : tail_q;
        count_d  = count_q;
        unique case ({push_acc, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d    = ovf_q | (push && !push_acc);
    end

    // Control state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; only written by accepted pushes
    always_ff @(posedge clk) begin
        if (reset && push_acc) begin
            store_q[tail_q] <= push_data;
        end
    end

    assign head_data = store_q[head_q];
    assign valid     = (count_q != '0);
    assign count     = count_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/data_memory_unit.sv
// Data-side memory stage: 64-word array with registered read data and one
// memory-mapped output port at IO_ADDR that feeds an output FIFO.
module data_memory_unit
    import data_memory_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [nBit-1:0] data_to_ram,
    input  logic [AW-1:0]   address_to_ram,
    input  logic            write_enable_to_ram,
    input  logic            read_enable_to_ram,
    input  logic            enable_ram_read,
    output logic [nBit-1:0] data_from_ram,
    output logic [nBit-1:0] io_data,
    output logic            io_valid,
    input  logic            io_ready,
    output logic [CW-1:0]   io_count,
    output logic            io_overflow
);

    localparam int unsigned Words = 2 ** AW;

    logic [nBit-1:0] mem_q [Words];
    logic [nBit-1:0] rdata_q, rdata_d;
    logic            is_io, do_read, arr_we, io_push;

    // Address decode and read mux; status reflects pre-edge FIFO state
    always_comb begin
        is_io   = (address_to_ram == IO_ADDR);
        do_read = read_enable_to_ram && enable_ram_read;
        arr_we  = write_enable_to_ram && !is_io;
        io_push = write_enable_to_ram && is_io;
        rdata_d = rdata_q;
        if (do_read) begin
            rdata_d = is_io ? status_word(io_overflow, io_count) : mem_q[address_to_ram];
        end
    end

    // Registered read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Data array; read-first because the read mux samples the old contents
    always_ff @(posedge clk) begin
        if (reset && arr_we) begin
            mem_q[address_to_ram] <= data_to_ram;
        end
    end

    assign data_from_ram = rdata_q;

    io_fifo #(
        .nBit       (nBit),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CW         (CW)
    ) u_io_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (io_push),
        .push_data  (data_to_ram),
        .pop_ready  (io_ready),
        .head_data  (io_data),
        .valid      (io_valid),
        .count      (io_count),
        .overflow   (io_overflow)
    );

endmodule
